// File: rtl/utx_frame_pkg.sv
// Shared UART definitions: line-state encodings (also used by the receiver),
// parity modes and the default oversampling ratio.
package utx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/utx_bittimer.sv
// Per-bit clock counter: counts 0..CLKS_PER_BIT-1 and strobes o_bit_end on the
// last clock of each bit period. i_clr restarts the period.
module utx_bittimer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= 8'd0;
        else if (i_clr || r_cnt == LAST)
            r_cnt <= 8'd0;
        else
            r_cnt <= r_cnt + 8'd1;
    end

    assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/utx_frame.sv
// 8-bit UART transmitter: one-deep holding register in front of a shift engine
// that frames start, LSB-first data, optional parity and 1/2 stop bits.
module utx_frame
    import utx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tvalid,
    input  logic [7:0] tdata,
    output logic       tready,
    output logic       tx,
    output logic       busy,
    output logic       tdone
);

    localparam bit   HAS_PAR   = (PARITY != PAR_NONE);
    localparam bit   ODD_PAR   = (PARITY == PAR_ODD);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e r_state, w_state_nxt;
    logic [7:0]  r_hold, r_shift, w_shift_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_stop, w_stop_nxt;
    logic        r_tready, r_tx, r_par;
    logic        w_tx_nxt, w_load, w_clr, w_bit_end;

    utx_bittimer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_clr),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_stop_nxt  = r_stop;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE:   w_load = !r_tready;
            ST_START:  if (w_bit_end) begin
                           w_state_nxt = ST_DATA;
                           w_idx_nxt   = 3'd0;
                       end
            ST_DATA:   if (w_bit_end) begin
                           w_shift_nxt = r_shift >> 1;
                           if (r_idx == 3'd7) begin
                               w_idx_nxt   = 3'd0;
                               w_stop_nxt  = 1'b0;
                               w_state_nxt = HAS_PAR ? ST_PARITY : ST_STOP;
                           end else begin
                               w_idx_nxt = r_idx + 3'd1;
                           end
                       end
            ST_PARITY: if (w_bit_end) begin
                           w_state_nxt = ST_STOP;
                           w_stop_nxt  = 1'b0;
                       end
            ST_STOP:   if (w_bit_end) begin
                           if (r_stop == LAST_STOP) begin
                               // Held byte chains straight into the next start bit.
                               if (!r_tready) w_load = 1'b1;
                               else           w_state_nxt = ST_IDLE;
                           end else begin
                               w_stop_nxt = r_stop + 1'b1;
                           end
                       end
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_load) begin
            w_state_nxt = ST_START;
            w_shift_nxt = r_hold;
        end
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = r_par ^ ODD_PAR;
            default:   w_tx_nxt = 1'b1;
        endcase
        w_clr = (w_state_nxt != r_state) || (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_tx     <= 1'b1;
            r_tready <= 1'b1;
            r_hold   <= 8'd0;
            r_shift  <= 8'd0;
            r_par    <= 1'b0;
            r_idx    <= 3'd0;
            r_stop   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_stop  <= w_stop_nxt;
            // Drain and accept never coincide: a drain needs tready low.
            if (w_load) begin
                r_tready <= 1'b1;
                r_par    <= ^r_hold;
            end else if (tvalid && r_tready) begin
                r_tready <= 1'b0;
                r_hold   <= tdata;
            end
        end
    end

    assign tready = r_tready;
    assign tx     = r_tx;
    assign busy   = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
    assign tdone  = (r_state == ST_STOP) && w_bit_end && (r_stop == LAST_STOP);

endmodule

// File: tb/tb_utx_frame.sv
// Bench for utx_frame: four configurations side by side, a line decoder per
// instance popping expected frames from a shared scoreboard queue.
module tb_utx_frame;
    import utx_frame_pkg::*;

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         len;
        logic       par;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tvalid = '0;
    logic [3:0] tready_w, tx_w, busy_w, tdone_w;
    logic [7:0] tdata [4];

    int   cyc = 0, checks = 0, failures = 0;
    int   nframes[4], tdone_cnt[4], fstart[4], fend[4], fdone[4], pdone[4], fgap[4];
    bit   mon_en[4];
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int g = 0; g < 4; g++)
            if (tdone_w[g] === 1'b1) tdone_cnt[g] <= tdone_cnt[g] + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_u
        localparam int CPB = (g == 1 || g == 2) ? 4 : 16;
        localparam int PAR = (g == 1) ? PAR_EVEN : (g == 2) ? PAR_ODD : PAR_NONE;
        localparam int NSB = (g == 3) ? 2 : 1;
        localparam int NS  = 10 + ((PAR != PAR_NONE) ? 1 : 0) + NSB - 1;

        utx_frame #(.CLKS_PER_BIT(CPB), .PARITY(PAR), .STOP_BITS(NSB)) u_dut (
            .clk    (clk),
            .rst    (rst),
            .tvalid (tvalid[g]),
            .tdata  (tdata[g]),
            .tready (tready_w[g]),
            .tx     (tx_w[g]),
            .busy   (busy_w[g]),
            .tdone  (tdone_w[g])
        );

        // Decode one frame per falling start edge; every clock of a slot must match.
        initial begin : mon
            int st, dn, len;
            logic [7:0] d;
            logic p, v;
            bit bad;
            exp_t e;
            forever begin
                @(negedge clk);
                if (mon_en[g] && rst === 1'b1 && tx_w[g] === 1'b0) begin
                    st = cyc; dn = -1; bad = 0; d = '0; p = 1'b0; v = 1'b0;
                    for (int s = 0; s < NS; s++) begin
                        for (int c = 0; c < CPB; c++) begin
                            if (!(s == 0 && c == 0)) @(negedge clk);
                            if (c == 0) v = tx_w[g];
                            else if (tx_w[g] !== v) bad = 1;
                            if (tdone_w[g] === 1'b1) begin
                                if (dn < 0) dn = cyc; else bad = 1;
                            end
                            if (busy_w[g] !== 1'b1) bad = 1;
                        end
                        if (s == 0) begin
                            if (v !== 1'b0) bad = 1;
                        end else if (s <= 8) d[s-1] = v;
                        else if (PAR != PAR_NONE && s == 9) p = v;
                        else if (v !== 1'b1) bad = 1;
                    end
                    len = (dn < 0) ? 0 : dn - st + 1;
                    fgap[g] = st - fend[g];
                    fstart[g] = st; fend[g] = cyc;
                    pdone[g] = fdone[g]; fdone[g] = dn;
                    nframes[g]++;
                    chk("frame expected", 32'(sbq.size() > 0), 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        chk("frame inst", g, e.inst);
                        chk("frame data", {24'd0, d}, {24'd0, e.data});
                        chk("frame len", len, e.len);
                        if (PAR != PAR_NONE) chk("frame parity", {31'd0, p}, {31'd0, e.par});
                        chk("frame shape", {31'd0, bad}, 0);
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] d, input int len, input logic par,
                        output int acc);
        int t = 0;
        exp_t e;
        @(negedge clk);
        tvalid[g] = 1'b1; tdata[g] = d;
        while (tready_w[g] !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
        chk("accept timeout", 32'(t < 1000), 1);
        @(posedge clk); #1;
        acc = cyc;
        tvalid[g] = 1'b0;
        e.inst = g; e.data = d; e.len = len; e.par = par;
        sbq.push_back(e);
    endtask

    task automatic wait_frames(input int g, input int n, input int budget);
        int t = 0;
        while (nframes[g] < n && t < budget) begin @(negedge clk); t++; end
        chk("frame wait", 32'(nframes[g] >= n), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp_t tbl[9];
        int n0, acc, k, dc, bp, idle_bad;
        for (int g = 0; g < 4; g++) begin tdata[g] = 8'd0; mon_en[g] = 1; end
        tbl[0] = '{0, 8'hC3, 160, 1'b0};
        tbl[1] = '{1, 8'h07,  44, 1'b1};
        tbl[2] = '{2, 8'h07,  44, 1'b0};
        tbl[3] = '{1, 8'h00,  44, 1'b0};
        tbl[4] = '{2, 8'h00,  44, 1'b1};
        tbl[5] = '{1, 8'hFF,  44, 1'b0};
        tbl[6] = '{2, 8'h80,  44, 1'b0};
        tbl[7] = '{3, 8'hFF, 176, 1'b0};
        tbl[8] = '{3, 8'h5A, 176, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst tx", tx_w, 4'hF);
        chk("rst tready", tready_w, 4'hF);
        chk("rst busy", busy_w, 0);
        chk("rst tdone", tdone_w, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            n0 = nframes[tbl[i].inst];
            send(tbl[i].inst, tbl[i].data, tbl[i].len, tbl[i].par, acc);
            wait_frames(tbl[i].inst, n0 + 1, 400);
            repeat (5) @(negedge clk);
        end

        // 8N1 0x55: exact start and tdone cycles relative to the accept edge
        n0 = nframes[0]; dc = tdone_cnt[0];
        send(0, 8'h55, 160, 1'b0, acc);
        chk("tx high at accept edge", tx_w[0], 1);
        chk("tready low after accept", tready_w[0], 0);
        chk("busy low while only held", busy_w[0], 0);
        @(posedge clk); #1;
        chk("tx start at N+1", tx_w[0], 0);
        chk("tready back at N+1", tready_w[0], 1);
        wait_frames(0, n0 + 1, 400);
        repeat (3) @(negedge clk);
        chk("start cycle", fstart[0] - acc, 1);
        chk("tdone cycle", fdone[0] - acc, 160);
        chk("tdone single pulse", tdone_cnt[0] - dc, 1);

        // back-to-back: second byte taken during DATA, no idle gap
        n0 = nframes[0]; dc = tdone_cnt[0];
        send(0, 8'hA3, 160, 1'b0, acc);
        repeat (40) @(negedge clk);
        send(0, 8'h0F, 160, 1'b0, k);
        wait_frames(0, n0 + 2, 600);
        repeat (3) @(negedge clk);
        chk("b2b gap", fgap[0], 1);
        chk("b2b tdone count", tdone_cnt[0] - dc, 2);
        chk("b2b tdone spacing", fdone[0] - pdone[0], 160);

        // backpressure: shifter and hold both full, 0x33 must be ignored
        n0 = nframes[0];
        send(0, 8'h11, 160, 1'b0, acc);
        send(0, 8'h22, 160, 1'b0, k);
        @(negedge clk);
        tvalid[0] = 1'b1; tdata[0] = 8'h33; bp = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tready_w[0] !== 1'b0) bp++;
        end
        tvalid[0] = 1'b0;
        chk("tready held low", bp, 0);
        wait_frames(0, n0 + 2, 600);
        repeat (200) @(negedge clk);
        chk("no extra frame", nframes[0] - n0, 2);
        chk("scoreboard drained", sbq.size(), 0);

        // reset during data bit 3 of 0x00
        mon_en[0] = 0; dc = tdone_cnt[0];
        send(0, 8'h00, 160, 1'b0, acc);
        void'(sbq.pop_back());
        while (cyc < acc + 70) @(negedge clk);
        chk("tx data bit3 low", tx_w[0], 0);
        #2 rst = 1'b0;
        #1;
        chk("mid rst tx", tx_w[0], 1);
        chk("mid rst tready", tready_w[0], 1);
        chk("mid rst busy", busy_w[0], 0);
        chk("mid rst tdone", tdone_w[0], 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || tready_w[0] !== 1'b1) idle_bad++;
        end
        chk("idle after reset", idle_bad, 0);
        chk("no tdone from aborted frame", tdone_cnt[0] - dc, 0);
        mon_en[0] = 1; n0 = nframes[0];
        send(0, 8'h5A, 160, 1'b0, acc);
        wait_frames(0, n0 + 1, 400);
        chk("post-reset start cycle", fstart[0] - acc, 1);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
